// File: rtl/bcd_pkg.sv
// Shared BCD types and helpers for the up/down counter family.
// Vectors are sized for the widest supported counter and zero-extended by the users.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE   = 4'd9;
  localparam int         MAX_DIGITS = 8;

  typedef logic [4*MAX_DIGITS-1:0] bcd_vec_t;

  // Elaboration-time conversion of a decimal integer into packed BCD, units in [3:0].
  function automatic bcd_vec_t to_bcd(input int value);
    bcd_vec_t r;
    int       v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input bcd_vec_t vec);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (vec[4*i +: 4] > BCD_NINE) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control and status bundle for one bcd_updown_counter instance.
interface bcd_updown_counter_if #(
  parameter int DIGITS = 2
);
  logic                  tick;
  logic                  up;
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   load_bcd;
  logic [4*DIGITS-1:0]   bcd;
  logic                  carry;
  logic                  at_max;
  logic                  at_zero;
  logic                  load_err;

  modport master (
    output tick, up, clear, load, load_bcd,
    input  bcd, carry, at_max, at_zero, load_err
  );

  modport slave (
    input  tick, up, clear, load, load_bcd,
    output bcd, carry, at_max, at_zero, load_err
  );
endinterface

// File: rtl/bcd_digit.sv
// Combinational single-digit BCD step cell; carry/borrow ripples from the units upward.
import bcd_pkg::*;

module bcd_digit (
  input  bcd_digit_t digit_i,
  input  logic       up_i,
  input  logic       cin_i,
  output bcd_digit_t digit_o,
  output logic       cout_o
);

  always_comb begin
    digit_o = digit_i;
    cout_o  = 1'b0;
    if (cin_i) begin
      if (up_i) begin
        if (digit_i >= BCD_NINE) begin
          digit_o = 4'd0;
          cout_o  = 1'b1;
        end else begin
          digit_o = digit_i + 4'd1;
        end
      end else begin
        if (digit_i == 4'd0) begin
          digit_o = BCD_NINE;
          cout_o  = 1'b1;
        end else begin
          digit_o = digit_i - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with arbitrary decimal modulus, load, clear and
// a registered wrap/borrow pulse for cascading stages.
import bcd_pkg::*;

module bcd_updown_counter #(
  parameter int DIGITS    = 2,
  parameter int MAX_VALUE = 99,
  parameter int SATURATE  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                up,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_bcd,
  output logic [4*DIGITS-1:0] bcd,
  output logic                carry,
  output logic                at_max,
  output logic                at_zero,
  output logic                load_err
);

  localparam int             W        = 4 * DIGITS;
  localparam bcd_vec_t       MAX_FULL = to_bcd(MAX_VALUE);
  localparam logic [W-1:0]   MAX_BCD  = MAX_FULL[W-1:0];

  logic [W-1:0]    bcd_q, bcd_d;
  logic            carry_q, carry_d;
  logic            load_err_q, load_err_d;

  logic [DIGITS:0] chain;
  logic [W-1:0]    stepped;
  bcd_vec_t        load_ext;
  logic            load_ok;
  logic            limit_hit;

  assign chain[0] = 1'b1;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_digit u_digit (
      .digit_i (bcd_q[4*gi +: 4]),
      .up_i    (up),
      .cin_i   (chain[gi]),
      .digit_o (stepped[4*gi +: 4]),
      .cout_o  (chain[gi+1])
    );
  end

  assign at_max  = (bcd_q == MAX_BCD);
  assign at_zero = (bcd_q == '0);

  // A decrement borrows out of the top digit exactly when the count is zero.
  assign limit_hit = up ? at_max : chain[DIGITS];

  always_comb begin
    load_ext        = '0;
    load_ext[W-1:0] = load_bcd;
  end

  // Valid BCD orders the same as its decimal value, so a plain compare works.
  assign load_ok = bcd_valid(load_ext) && (load_bcd <= MAX_BCD);

  always_comb begin
    bcd_d      = bcd_q;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    if (clear) begin
      bcd_d = '0;
    end else if (load) begin
      if (load_ok) bcd_d = load_bcd;
      else         load_err_d = 1'b1;
    end else if (tick) begin
      if (limit_hit) begin
        if (SATURATE == 0) begin
          bcd_d   = up ? '0 : MAX_BCD;
          carry_d = 1'b1;
        end
      end else begin
        bcd_d = stepped;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_q      <= '0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      bcd_q      <= bcd_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  assign bcd      = bcd_q;
  assign carry    = carry_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: several parameterisations plus a two-stage cascade.
module tb_bcd_updown_counter;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bcd_updown_counter_if #(.DIGITS(2)) u99_if ();
  bcd_updown_counter_if #(.DIGITS(2)) w59_if ();
  bcd_updown_counter_if #(.DIGITS(2)) s59_if ();
  bcd_updown_counter_if #(.DIGITS(4)) d4_if ();
  bcd_updown_counter_if #(.DIGITS(2)) lo_if ();
  bcd_updown_counter_if #(.DIGITS(2)) hi_if ();

  // Upper stage ticks on the lower stage's carry and shares its direction.
  assign hi_if.tick = lo_if.carry;
  assign hi_if.up   = lo_if.up;

  bcd_updown_counter #(.DIGITS(2), .MAX_VALUE(99), .SATURATE(0)) u_c99 (
    .clk(clk), .reset(reset), .tick(u99_if.tick), .up(u99_if.up), .clear(u99_if.clear),
    .load(u99_if.load), .load_bcd(u99_if.load_bcd), .bcd(u99_if.bcd), .carry(u99_if.carry),
    .at_max(u99_if.at_max), .at_zero(u99_if.at_zero), .load_err(u99_if.load_err));

  bcd_updown_counter #(.DIGITS(2), .MAX_VALUE(59), .SATURATE(0)) u_w59 (
    .clk(clk), .reset(reset), .tick(w59_if.tick), .up(w59_if.up), .clear(w59_if.clear),
    .load(w59_if.load), .load_bcd(w59_if.load_bcd), .bcd(w59_if.bcd), .carry(w59_if.carry),
    .at_max(w59_if.at_max), .at_zero(w59_if.at_zero), .load_err(w59_if.load_err));

  bcd_updown_counter #(.DIGITS(2), .MAX_VALUE(59), .SATURATE(1)) u_s59 (
    .clk(clk), .reset(reset), .tick(s59_if.tick), .up(s59_if.up), .clear(s59_if.clear),
    .load(s59_if.load), .load_bcd(s59_if.load_bcd), .bcd(s59_if.bcd), .carry(s59_if.carry),
    .at_max(s59_if.at_max), .at_zero(s59_if.at_zero), .load_err(s59_if.load_err));

  bcd_updown_counter #(.DIGITS(4), .MAX_VALUE(9999), .SATURATE(0)) u_d4 (
    .clk(clk), .reset(reset), .tick(d4_if.tick), .up(d4_if.up), .clear(d4_if.clear),
    .load(d4_if.load), .load_bcd(d4_if.load_bcd), .bcd(d4_if.bcd), .carry(d4_if.carry),
    .at_max(d4_if.at_max), .at_zero(d4_if.at_zero), .load_err(d4_if.load_err));

  bcd_updown_counter #(.DIGITS(2), .MAX_VALUE(59), .SATURATE(0)) u_lo (
    .clk(clk), .reset(reset), .tick(lo_if.tick), .up(lo_if.up), .clear(lo_if.clear),
    .load(lo_if.load), .load_bcd(lo_if.load_bcd), .bcd(lo_if.bcd), .carry(lo_if.carry),
    .at_max(lo_if.at_max), .at_zero(lo_if.at_zero), .load_err(lo_if.load_err));

  bcd_updown_counter #(.DIGITS(2), .MAX_VALUE(59), .SATURATE(0)) u_hi (
    .clk(clk), .reset(reset), .tick(hi_if.tick), .up(hi_if.up), .clear(hi_if.clear),
    .load(hi_if.load), .load_bcd(hi_if.load_bcd), .bcd(hi_if.bcd), .carry(hi_if.carry),
    .at_max(hi_if.at_max), .at_zero(hi_if.at_zero), .load_err(hi_if.load_err));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] dec2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  int carries;

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    carries = 0;
    reset   = 1'b1;
    {u99_if.tick, u99_if.up, u99_if.clear, u99_if.load} = '0; u99_if.load_bcd = '0;
    {w59_if.tick, w59_if.up, w59_if.clear, w59_if.load} = '0; w59_if.load_bcd = '0;
    {s59_if.tick, s59_if.up, s59_if.clear, s59_if.load} = '0; s59_if.load_bcd = '0;
    {d4_if.tick,  d4_if.up,  d4_if.clear,  d4_if.load}  = '0; d4_if.load_bcd  = '0;
    {lo_if.tick,  lo_if.up,  lo_if.clear,  lo_if.load}  = '0; lo_if.load_bcd  = '0;
    hi_if.clear = 1'b0; hi_if.load = 1'b0; hi_if.load_bcd = '0;
    step();
    step();
    reset = 1'b0;

    check("rst_bcd",      32'(u99_if.bcd),      32'h00);
    check("rst_at_zero",  32'(u99_if.at_zero),  32'd1);
    check("rst_at_max",   32'(u99_if.at_max),   32'd0);
    check("rst_carry",    32'(u99_if.carry),    32'd0);
    check("rst_load_err", 32'(u99_if.load_err), 32'd0);

    // 100 up-ticks: 01..99 then 00 with a single carry.
    u99_if.tick = 1'b1; u99_if.up = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step();
      check("up99_bcd",   32'(u99_if.bcd),   32'(dec2(i % 100)));
      check("up99_carry", 32'(u99_if.carry), 32'(i == 100));
      if (u99_if.carry) carries++;
      if (i == 99) check("up99_at_max", 32'(u99_if.at_max), 32'd1);
    end
    u99_if.tick = 1'b0;
    check("up99_ncarry", 32'(carries), 32'd1);

    // MAX=59 wrap: load 58, up to 59, wrap to 00, borrow back to 59.
    w59_if.load = 1'b1; w59_if.load_bcd = 8'h58;
    step();
    w59_if.load = 1'b0;
    check("w59_load", 32'(w59_if.bcd), 32'h58);
    w59_if.tick = 1'b1; w59_if.up = 1'b1;
    step();
    check("w59_59",     32'(w59_if.bcd),    32'h59);
    check("w59_at_max", 32'(w59_if.at_max), 32'd1);
    check("w59_c0",     32'(w59_if.carry),  32'd0);
    step();
    check("w59_wrap",   32'(w59_if.bcd),    32'h00);
    check("w59_wrap_c", 32'(w59_if.carry),  32'd1);
    w59_if.up = 1'b0;
    step();
    check("w59_borrow",   32'(w59_if.bcd),   32'h59);
    check("w59_borrow_c", 32'(w59_if.carry), 32'd1);
    w59_if.tick = 1'b0;
    step();
    check("w59_c_clr", 32'(w59_if.carry), 32'd0);
    w59_if.load = 1'b1; w59_if.load_bcd = 8'h60;
    step();
    w59_if.load = 1'b0;
    check("w59_big_err", 32'(w59_if.load_err), 32'd1);
    check("w59_big_bcd", 32'(w59_if.bcd),      32'h59);

    // MAX=59 saturate: hold at 59 going up, hold at 00 going down.
    s59_if.load = 1'b1; s59_if.load_bcd = 8'h59;
    step();
    s59_if.load = 1'b0;
    check("s59_load_c", 32'(s59_if.carry), 32'd0);
    s59_if.tick = 1'b1; s59_if.up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("s59_hold",   32'(s59_if.bcd),   32'h59);
      check("s59_hold_c", 32'(s59_if.carry), 32'd0);
    end
    s59_if.tick = 1'b0; s59_if.clear = 1'b1;
    step();
    s59_if.clear = 1'b0;
    check("s59_clear", 32'(s59_if.bcd), 32'h00);
    s59_if.tick = 1'b1; s59_if.up = 1'b0;
    step();
    s59_if.tick = 1'b0;
    check("s59_zero",    32'(s59_if.bcd),     32'h00);
    check("s59_at_zero", 32'(s59_if.at_zero), 32'd1);
    check("s59_zero_c",  32'(s59_if.carry),   32'd0);

    // Four digits: illegal digit rejected, ripple 0999 -> 1000 and back.
    d4_if.load = 1'b1; d4_if.load_bcd = 16'h1A00;
    step();
    d4_if.load = 1'b0;
    check("d4_err",     32'(d4_if.load_err), 32'd1);
    check("d4_err_bcd", 32'(d4_if.bcd),      32'h0000);
    d4_if.load = 1'b1; d4_if.load_bcd = 16'h0999;
    step();
    d4_if.load = 1'b0;
    check("d4_err_drop", 32'(d4_if.load_err), 32'd0);
    check("d4_load",     32'(d4_if.bcd),      32'h0999);
    d4_if.tick = 1'b1; d4_if.up = 1'b1;
    step();
    check("d4_ripple_up", 32'(d4_if.bcd), 32'h1000);
    d4_if.up = 1'b0;
    step();
    d4_if.tick = 1'b0;
    check("d4_ripple_dn", 32'(d4_if.bcd), 32'h0999);
    d4_if.load = 1'b1; d4_if.load_bcd = 16'h9999;
    step();
    d4_if.load = 1'b0;
    check("d4_ldmax_max", 32'(d4_if.at_max),   32'd1);
    check("d4_ldmax_c",   32'(d4_if.carry),    32'd0);
    check("d4_ldmax_err", 32'(d4_if.load_err), 32'd0);

    // Priority: clear beats load and tick; load beats tick.
    u99_if.load = 1'b1; u99_if.load_bcd = 8'h99;
    step();
    u99_if.clear = 1'b1; u99_if.load_bcd = 8'h42; u99_if.tick = 1'b1; u99_if.up = 1'b1;
    step();
    u99_if.clear = 1'b0; u99_if.tick = 1'b0; u99_if.load_bcd = 8'h05;
    check("pri_clr_bcd", 32'(u99_if.bcd),   32'h00);
    check("pri_clr_c",   32'(u99_if.carry), 32'd0);
    step();
    check("pri_ld05", 32'(u99_if.bcd), 32'h05);
    u99_if.load_bcd = 8'h42; u99_if.tick = 1'b1;
    step();
    u99_if.load = 1'b0; u99_if.tick = 1'b0;
    check("pri_ld_tick", 32'(u99_if.bcd), 32'h42);

    // Cascade 59/59: upper stage lags one cycle behind each lower wrap.
    lo_if.tick = 1'b1; lo_if.up = 1'b1;
    for (int n = 1; n <= 120; n++) begin
      step();
      check("cas_lo", 32'(lo_if.bcd), 32'(dec2(n % 60)));
      check("cas_hi", 32'(hi_if.bcd), 32'(dec2((n - 1) / 60)));
    end
    check("cas_lo_c", 32'(lo_if.carry), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0; lo_if.tick = 1'b0;
    check("cas_rst_lo",   32'(lo_if.bcd),   32'h00);
    check("cas_rst_hi",   32'(hi_if.bcd),   32'h00);
    check("cas_rst_c",    32'(lo_if.carry), 32'd0);
    step();
    check("cas_rst_hi2",  32'(hi_if.bcd),   32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
